cp0_core: RTL and testbench

CP0_CORE -- requirements
Module: cp0_core

---
 rtl/cp0_pkg.sv | 39 +++
 rtl/cp0_timer.sv | 51 +++++
 rtl/cp0_core.sv | 154 +++++++++++++++
 tb/tb_cp0_core.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register addresses, exception codes and the
// bit positions used to assemble Status and Cause.
package cp0_pkg;

  // Register addresses, encoded as {rd[4:0], sel[2:0]}
  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Status bit positions
  localparam int STATUS_BEV   = 22;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IE    = 0;

  // Cause bit positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IPHW_LO = 10;
  localparam int CAUSE_IPSW_HI = 9;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: prescaler, free-running Count, Compare and the sticky timer
// interrupt flag TI.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             div_tick;

  // Count advances on the last cycle of each prescaler period
  assign div_tick = (div == DIV_W'(COUNT_DIV - 1));

  // Prescaler/Count/Compare/TI state; software writes beat hardware updates
  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else if (div_tick) begin
        count <= count + 32'd1;
        div   <= '0;
      end else begin
        div <= div + 1'b1;
      end

      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_core.sv
// CP0 core: Status/Cause/EPC/BadVAddr, exception and eret bookkeeping,
// interrupt sampling and request generation, optional timer.
module cp0_core
  import cp0_pkg::*;
#(
  parameter int N_EXT_INT = 6,
  parameter int COUNT_DIV = 2,
  parameter int HAS_TIMER = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_ex,
  input  logic                 wb_bd,
  input  logic [4:0]           wb_excode,
  input  logic [31:0]          wb_pc,
  input  logic [31:0]          wb_badvaddr,
  input  logic                 wb_eret,
  input  logic [N_EXT_INT-1:0] ext_int_in,
  input  logic [7:0]           cp0_addr,
  input  logic                 mtc0_we,
  input  logic [31:0]          cp0_wdata,
  output logic [31:0]          cp0_rdata,
  output logic [31:0]          cp0_epc,
  output logic [31:0]          cp0_status,
  output logic [31:0]          cp0_cause,
  output logic                 int_req
);

  logic [7:0]           im;
  logic                 exl;
  logic                 ie;
  logic                 bd;
  logic [1:0]           ip_sw;
  logic [4:0]           exccode;
  logic [31:0]          epc;
  logic [31:0]          badvaddr;
  logic [N_EXT_INT-1:0] int_sample;
  logic [5:0]           ip_hw;
  logic [31:0]          count;
  logic [31:0]          compare;
  logic                 ti;
  logic                 sw_we;
  logic                 count_we;
  logic                 compare_we;

  // Software writes lose to any exception or eret in the same cycle
  assign sw_we      = mtc0_we & ~wb_ex & ~wb_eret;
  assign count_we   = sw_we & (cp0_addr == ADDR_COUNT);
  assign compare_we = sw_we & (cp0_addr == ADDR_COMPARE);

  if (HAS_TIMER != 0) begin : g_timer
    cp0_timer #(
      .COUNT_DIV (COUNT_DIV)
    ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (count_we),
      .compare_we (compare_we),
      .wdata      (cp0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
    );
  end else begin : g_no_timer
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
  end

  // Hardware IP bits: sampled lines, with the timer folded into IP[7]
  always_comb begin
    ip_hw                = '0;
    ip_hw[N_EXT_INT-1:0] = int_sample;
    ip_hw[5]             = ip_hw[5] | ti;
  end

  // Assemble Status and Cause from their implemented fields
  always_comb begin
    cp0_status                            = '0;
    cp0_status[STATUS_BEV]                = 1'b1;
    cp0_status[STATUS_IM_HI:STATUS_IM_LO] = im;
    cp0_status[STATUS_EXL]                = exl;
    cp0_status[STATUS_IE]                 = ie;

    cp0_cause                              = '0;
    cp0_cause[CAUSE_BD]                    = bd;
    cp0_cause[CAUSE_TI]                    = ti;
    cp0_cause[CAUSE_IP_HI:CAUSE_IPHW_LO]   = ip_hw;
    cp0_cause[CAUSE_IPSW_HI:CAUSE_IP_LO]   = ip_sw;
    cp0_cause[CAUSE_EXC_HI:CAUSE_EXC_LO]   = exccode;
  end

  assign cp0_epc = epc;

  assign int_req = ie & ~exl &
                   (|(cp0_cause[CAUSE_IP_HI:CAUSE_IP_LO] &
                      cp0_status[STATUS_IM_HI:STATUS_IM_LO]));

  // Read mux sees pre-write state; unmapped addresses return zero
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr;
      ADDR_COUNT:    cp0_rdata = count;
      ADDR_COMPARE:  cp0_rdata = compare;
      ADDR_STATUS:   cp0_rdata = cp0_status;
      ADDR_CAUSE:    cp0_rdata = cp0_cause;
      ADDR_EPC:      cp0_rdata = epc;
      default:       cp0_rdata = '0;
    endcase
  end

  // Register updates: exception, then eret, then software write
  always_ff @(posedge clk) begin
    if (reset) begin
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd         <= 1'b0;
      ip_sw      <= '0;
      exccode    <= '0;
      epc        <= '0;
      badvaddr   <= '0;
      int_sample <= '0;
    end else begin
      int_sample <= ext_int_in;
      if (wb_ex) begin
        exl     <= 1'b1;
        exccode <= wb_excode;
        if (!exl) begin
          epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
          bd  <= wb_bd;
        end
        if (wb_excode == EXC_ADEL || wb_excode == EXC_ADES) begin
          badvaddr <= wb_badvaddr;
        end
      end else if (wb_eret) begin
        exl <= 1'b0;
      end else if (mtc0_we) begin
        case (cp0_addr)
          ADDR_STATUS: begin
            im  <= cp0_wdata[STATUS_IM_HI:STATUS_IM_LO];
            exl <= cp0_wdata[STATUS_EXL];
            ie  <= cp0_wdata[STATUS_IE];
          end
          ADDR_CAUSE: ip_sw <= cp0_wdata[CAUSE_IPSW_HI:CAUSE_IP_LO];
          ADDR_EPC:   epc   <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_core.sv
// Directed testbench for cp0_core with default parameters
// (6 interrupt lines, Count every 2 cycles, timer present).
module tb_cp0_core;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_ex, wb_bd, wb_eret, mtc0_we;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, cp0_wdata;
  logic [5:0]  ext_int_in;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_rdata, cp0_epc, cp0_status, cp0_cause;
  logic        int_req;

  int vectors = 0;
  int miscompares = 0;

  cp0_core #(.N_EXT_INT(6), .COUNT_DIV(2), .HAS_TIMER(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_ex       (wb_ex),
    .wb_bd       (wb_bd),
    .wb_excode   (wb_excode),
    .wb_pc       (wb_pc),
    .wb_badvaddr (wb_badvaddr),
    .wb_eret     (wb_eret),
    .ext_int_in  (ext_int_in),
    .cp0_addr    (cp0_addr),
    .mtc0_we     (mtc0_we),
    .cp0_wdata   (cp0_wdata),
    .cp0_rdata   (cp0_rdata),
    .cp0_epc     (cp0_epc),
    .cp0_status  (cp0_status),
    .cp0_cause   (cp0_cause),
    .int_req     (int_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    cp0_addr  = a;
    cp0_wdata = d;
    mtc0_we   = 1'b1;
    tick();
    mtc0_we   = 1'b0;
  endtask

  task automatic raise_ex(input logic bd, input logic [4:0] code,
                          input logic [31:0] pc, input logic [31:0] bva);
    wb_ex = 1'b1; wb_bd = bd; wb_excode = code; wb_pc = pc; wb_badvaddr = bva;
    tick();
    wb_ex = 1'b0; wb_bd = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    vectors++; if (cp0_status !== 32'h0040_0000) begin miscompares++; $display("[TB] FAIL reset_status: got %h want %h", cp0_status, 32'h0040_0000); end
    vectors++; if (cp0_cause !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_cause: got %h want %h", cp0_cause, 32'h0); end
    vectors++; if (cp0_epc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_epc: got %h want %h", cp0_epc, 32'h0); end
    vectors++; if (int_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_int_req: got %b want 0", int_req); end
    read_reg(ADDR_COUNT, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_count: got %h want %h", r, 32'h0); end
    read_reg(8'h08, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("[TB] FAIL unmapped_read: got %h want %h", r, 32'h0); end
  endtask

  task automatic test_exception();
    logic [31:0] r;
    raise_ex(1'b1, EXC_SYS, 32'hBFC0_0104, 32'hCAFE_0000);
    vectors++; if (cp0_epc !== 32'hBFC0_0100) begin miscompares++; $display("[TB] FAIL ex_epc: got %h want %h", cp0_epc, 32'hBFC0_0100); end
    vectors++; if (cp0_cause[31] !== 1'b1) begin miscompares++; $display("[TB] FAIL ex_bd: got %b want 1", cp0_cause[31]); end
    vectors++; if (cp0_status[1] !== 1'b1) begin miscompares++; $display("[TB] FAIL ex_exl: got %b want 1", cp0_status[1]); end
    vectors++; if (cp0_cause[6:2] !== 5'h08) begin miscompares++; $display("[TB] FAIL ex_code: got %h want %h", cp0_cause[6:2], 5'h08); end
    read_reg(ADDR_BADVADDR, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("[TB] FAIL ex_badvaddr_kept: got %h want %h", r, 32'h0); end
  endtask

  task automatic test_nested();
    logic [31:0] r;
    raise_ex(1'b0, EXC_ADEL, 32'h8000_0200, 32'h1234_5679);
    vectors++; if (cp0_epc !== 32'hBFC0_0100) begin miscompares++; $display("[TB] FAIL nest_epc: got %h want %h", cp0_epc, 32'hBFC0_0100); end
    vectors++; if (cp0_cause[31] !== 1'b1) begin miscompares++; $display("[TB] FAIL nest_bd: got %b want 1", cp0_cause[31]); end
    vectors++; if (cp0_cause[6:2] !== 5'h04) begin miscompares++; $display("[TB] FAIL nest_code: got %h want %h", cp0_cause[6:2], 5'h04); end
    read_reg(ADDR_BADVADDR, r);
    vectors++; if (r !== 32'h1234_5679) begin miscompares++; $display("[TB] FAIL nest_badvaddr: got %h want %h", r, 32'h1234_5679); end
    wb_eret = 1'b1; tick(); wb_eret = 1'b0;
    vectors++; if (cp0_status[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL eret_exl: got %b want 0", cp0_status[1]); end
    raise_ex(1'b0, EXC_RI, 32'h8000_1000, 32'hDEAD_BEEF);
    vectors++; if (cp0_epc !== 32'h8000_1000) begin miscompares++; $display("[TB] FAIL ri_epc: got %h want %h", cp0_epc, 32'h8000_1000); end
    vectors++; if (cp0_cause[31] !== 1'b0) begin miscompares++; $display("[TB] FAIL ri_bd: got %b want 0", cp0_cause[31]); end
    read_reg(ADDR_BADVADDR, r);
    vectors++; if (r !== 32'h1234_5679) begin miscompares++; $display("[TB] FAIL ri_badvaddr_kept: got %h want %h", r, 32'h1234_5679); end
    wb_eret = 1'b1; tick(); wb_eret = 1'b0;
  endtask

  task automatic test_rdata_before_write();
    cp0_addr = ADDR_EPC; cp0_wdata = 32'h1111_0000; mtc0_we = 1'b1;
    #1;
    vectors++; if (cp0_rdata !== 32'h8000_1000) begin miscompares++; $display("[TB] FAIL rdata_prewrite: got %h want %h", cp0_rdata, 32'h8000_1000); end
    tick(); mtc0_we = 1'b0;
    vectors++; if (cp0_epc !== 32'h1111_0000) begin miscompares++; $display("[TB] FAIL epc_write: got %h want %h", cp0_epc, 32'h1111_0000); end
  endtask

  task automatic test_timer();
    logic [31:0] r;
    mtc0(ADDR_COUNT, 32'd100);
    mtc0(ADDR_STATUS, 32'h0000_8001);
    mtc0(ADDR_COMPARE, 32'd5);
    vectors++; if (cp0_cause[30] !== 1'b0) begin miscompares++; $display("[TB] FAIL cmp_clears_ti: got %b want 0", cp0_cause[30]); end
    vectors++; if (int_req !== 1'b0) begin miscompares++; $display("[TB] FAIL cmp_int_req: got %b want 0", int_req); end
    mtc0(ADDR_COUNT, 32'd0);
    read_reg(ADDR_COUNT, r);
    vectors++; if (r !== 32'd0) begin miscompares++; $display("[TB] FAIL count_load: got %h want %h", r, 32'd0); end
    repeat (9) tick();
    read_reg(ADDR_COUNT, r);
    vectors++; if (r !== 32'd4) begin miscompares++; $display("[TB] FAIL count_9cyc: got %h want %h", r, 32'd4); end
    tick();
    read_reg(ADDR_COUNT, r);
    vectors++; if (r !== 32'd5) begin miscompares++; $display("[TB] FAIL count_10cyc: got %h want %h", r, 32'd5); end
    vectors++; if (cp0_cause[30] !== 1'b0) begin miscompares++; $display("[TB] FAIL ti_early: got %b want 0", cp0_cause[30]); end
    tick();
    vectors++; if (cp0_cause[30] !== 1'b1) begin miscompares++; $display("[TB] FAIL ti_set: got %b want 1", cp0_cause[30]); end
    vectors++; if (cp0_cause[15] !== 1'b1) begin miscompares++; $display("[TB] FAIL ip7_ti: got %b want 1", cp0_cause[15]); end
    vectors++; if (int_req !== 1'b1) begin miscompares++; $display("[TB] FAIL timer_int_req: got %b want 1", int_req); end
    mtc0(ADDR_COMPARE, 32'h0000_1000);
    vectors++; if (cp0_cause[30] !== 1'b0) begin miscompares++; $display("[TB] FAIL ti_clear: got %b want 0", cp0_cause[30]); end
    vectors++; if (int_req !== 1'b0) begin miscompares++; $display("[TB] FAIL ti_clear_int_req: got %b want 0", int_req); end
  endtask

  task automatic test_count_wrap();
    logic [31:0] r;
    mtc0(ADDR_COUNT, 32'hFFFF_FFFF);
    tick();
    read_reg(ADDR_COUNT, r);
    vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL wrap_hold: got %h want %h", r, 32'hFFFF_FFFF); end
    tick();
    read_reg(ADDR_COUNT, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_zero: got %h want %h", r, 32'h0); end
    tick();
    mtc0(ADDR_COUNT, 32'h55);
    read_reg(ADDR_COUNT, r);
    vectors++; if (r !== 32'h55) begin miscompares++; $display("[TB] FAIL write_vs_tick: got %h want %h", r, 32'h55); end
  endtask

  task automatic test_interrupt();
    mtc0(ADDR_STATUS, 32'h0000_0801);
    ext_int_in = 6'b000010;
    #1;
    vectors++; if (cp0_cause[11] !== 1'b0) begin miscompares++; $display("[TB] FAIL ip_latency: got %b want 0", cp0_cause[11]); end
    tick();
    vectors++; if (cp0_cause[11] !== 1'b1) begin miscompares++; $display("[TB] FAIL ip11_set: got %b want 1", cp0_cause[11]); end
    vectors++; if (int_req !== 1'b1) begin miscompares++; $display("[TB] FAIL hw_int_req: got %b want 1", int_req); end
    cp0_addr = ADDR_STATUS; cp0_wdata = 32'h0; mtc0_we = 1'b1;
    raise_ex(1'b0, EXC_INT, 32'h8000_2000, 32'h0);
    mtc0_we = 1'b0;
    vectors++; if (cp0_status !== 32'h0040_0803) begin miscompares++; $display("[TB] FAIL status_write_ignored: got %h want %h", cp0_status, 32'h0040_0803); end
    vectors++; if (int_req !== 1'b0) begin miscompares++; $display("[TB] FAIL exl_masks_int: got %b want 0", int_req); end
    vectors++; if (cp0_epc !== 32'h8000_2000) begin miscompares++; $display("[TB] FAIL int_epc: got %h want %h", cp0_epc, 32'h8000_2000); end
    ext_int_in = 6'b0;
    wb_eret = 1'b1; tick(); wb_eret = 1'b0;
    mtc0(ADDR_CAUSE, 32'hFFFF_FFFF);
    vectors++; if (cp0_cause !== 32'h0000_0300) begin miscompares++; $display("[TB] FAIL cause_sw_write: got %h want %h", cp0_cause, 32'h0000_0300); end
    vectors++; if (int_req !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_ip_masked: got %b want 0", int_req); end
    mtc0(ADDR_STATUS, 32'h0000_0201);
    vectors++; if (int_req !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_int_req: got %b want 1", int_req); end
    mtc0(ADDR_CAUSE, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    raise_ex(1'b0, EXC_SYS, 32'h8000_3000, 32'h0);
    mtc0(ADDR_COUNT, 32'd7);
    repeat (3) tick();
    reset = 1'b1; wb_ex = 1'b1; wb_excode = EXC_ADES; wb_badvaddr = 32'h9999_0000;
    wb_eret = 1'b1; mtc0_we = 1'b1; cp0_addr = ADDR_EPC; cp0_wdata = 32'h5555_5555;
    tick();
    wb_ex = 1'b0; wb_eret = 1'b0; mtc0_we = 1'b0;
    vectors++; if (cp0_status !== 32'h0040_0000) begin miscompares++; $display("[TB] FAIL mid_reset_status: got %h want %h", cp0_status, 32'h0040_0000); end
    vectors++; if (cp0_cause !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_cause: got %h want %h", cp0_cause, 32'h0); end
    vectors++; if (cp0_epc !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_epc: got %h want %h", cp0_epc, 32'h0); end
    vectors++; if (int_req !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_int_req: got %b want 0", int_req); end
    read_reg(ADDR_COUNT, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_count: got %h want %h", r, 32'h0); end
    read_reg(ADDR_COMPARE, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_compare: got %h want %h", r, 32'h0); end
    read_reg(ADDR_BADVADDR, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_badvaddr: got %h want %h", r, 32'h0); end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wb_ex = 1'b0; wb_bd = 1'b0; wb_eret = 1'b0; mtc0_we = 1'b0;
    wb_excode = '0; wb_pc = '0; wb_badvaddr = '0; cp0_wdata = '0;
    ext_int_in = '0; cp0_addr = '0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_exception();
    test_nested();
    test_rdata_before_write();
    test_timer();
    test_count_wrap();
    test_interrupt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
